// File: rtl/wb_burst_master.sv
// Wishbone burst master: one app command -> one Wishbone cycle.
// Classic single beats, incrementing bursts, stall watchdog.
module wb_burst_master #(
  parameter int APP_AW  = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DW-1:0]     wdat_data,
  input  logic [DW/8-1:0]   wdat_sel,
  output logic              rdat_valid,
  output logic [DW-1:0]     rdat_data,
  output logic              rdat_last,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic          single_q;
  logic [3:0]    rem_q;
  logic [4:0]    pend_q;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] wd_cnt;

  logic ack_v;
  logic last_ack;
  logic wd_hit;
  logic wd_abort;
  logic accept;
  logic wr_hs;
  logic beats_left;
  logic in_xfer;

  assign in_xfer    = (state == XFER);
  assign ack_v      = wb_stb_o & wb_ack_i;
  assign last_ack   = ack_v & (rem_q == 4'd0);
  assign wd_hit     = (wd_cnt == CW'(TIMEOUT - 1));
  assign wd_abort   = in_xfer & wb_stb_o & ~wb_ack_i & wd_hit;
  assign accept     = (state == IDLE) & cmd_valid;
  assign beats_left = (pend_q != 5'd0);
  assign wr_hs      = wdat_valid & wdat_ready;

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  // next-state: abort wins over completion
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nx = XFER;
      XFER: begin
        if (wd_abort)      state_nx = IDLE;
        else if (last_ack) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded handshake and status outputs
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    wdat_ready = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      XFER: begin
        wdat_ready = wb_we_o & (~wb_stb_o | wb_ack_i)
                   & beats_left;
      end
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // cti and sel are idle-zero; cti follows beats remaining
  always_comb begin
    wb_cti_o = 3'b000;
    wb_sel_o = '0;
    if (wb_cyc_o) begin
      unique case (1'b1)
        single_q:          wb_cti_o = 3'b000;
        (rem_q != 4'd0):   wb_cti_o = 3'b010;
        default:           wb_cti_o = 3'b111;
      endcase
      wb_sel_o = wb_we_o ? sel_q : {SW{1'b1}};
    end
  end

  // bus datapath: command latch, beat stepping, read capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_dat_o   <= '0;
      sel_q      <= '0;
      single_q   <= 1'b0;
      rem_q      <= '0;
      pend_q     <= '0;
      rdat_valid <= 1'b0;
      rdat_data  <= '0;
      rdat_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      rdat_valid <= 1'b0;
      rdat_last  <= 1'b0;
      err        <= wd_abort;
      if (accept) begin
        wb_we_o   <= cmd_we;
        wb_addr_o <= {cmd_addr[APP_AW-1:2], 2'b00};
        rem_q     <= cmd_len;
        pend_q    <= {1'b0, cmd_len} + 5'd1;
        single_q  <= (cmd_len == 4'd0);
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= ~cmd_we;
      end
      if (in_xfer) begin
        if (wd_abort) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end else begin
          if (ack_v) begin
            wb_addr_o <= wb_addr_o + APP_AW'(4);
            rem_q     <= rem_q - 4'd1;
            if (!wb_we_o) begin
              rdat_valid <= 1'b1;
              rdat_data  <= wb_dat_i;
              rdat_last  <= (rem_q == 4'd0);
            end
          end
          if (last_ack) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end else if (wr_hs) begin
            wb_dat_o <= wdat_data;
            sel_q    <= wdat_sel;
            wb_stb_o <= 1'b1;
            pend_q   <= pend_q - 5'd1;
          end else if (ack_v && wb_we_o) begin
            wb_stb_o <= 1'b0;
          end
        end
      end
    end
  end

  // watchdog: consecutive strobed cycles without ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_cnt <= '0;
    end else if (in_xfer && wb_stb_o && !wb_ack_i
                 && !wd_abort) begin
      wd_cnt <= wd_cnt + CW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a
// zero-wait memory slave and a write-data driver.
module tb_wb_burst_master;

  localparam int AW = 26;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic          wdat_valid = 1'b0;
  logic          wdat_ready;
  logic [31:0]   wdat_data = '0;
  logic [3:0]    wdat_sel = '0;
  logic          rdat_valid;
  logic [31:0]   rdat_data;
  logic          rdat_last;
  logic          done;
  logic          err;
  logic          busy;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [31:0]   wb_dat_i;

  logic          ack_en;
  logic          tog;
  logic [31:0]   mem [1024];
  logic [31:0]   ref_mem [1024];
  bit            seeded = 1'b0;

  logic [31:0] wq_d [512];
  logic [3:0]  wq_s [512];
  int          wn;
  int          wi = 0;
  bit          phase = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;

  int          cyc_n = 0;
  int          n_stb = 0;
  int          n_gap = 0;
  int          n_beats = 0;
  int          n_rd = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [AW-1:0] b_addr [512];
  logic [2:0]  b_cti [512];
  logic [31:0] b_dat [512];
  logic        b_we [512];
  int          b_cyc [512];
  logic [31:0] r_dat [512];
  logic        r_last [512];
  int          r_cyc [512];
  int          done_cyc = 0;
  logic [2:0]  done_snap = '0;
  logic [2:0]  err_snap = '0;

  always #5 clk = ~clk;

  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_dat_i = mem[wb_addr_o[11:2]];

  wb_burst_master #(
    .APP_AW (AW),
    .DW     (32),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready),
    .wdat_data (wdat_data),
    .wdat_sel  (wdat_sel),
    .rdat_valid(rdat_valid),
    .rdat_data (rdat_data),
    .rdat_last (rdat_last),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_cti_o  (wb_cti_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i)
  );

  // slave memory and bus/stream monitor
  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 1024; i++)
        mem[i] = 32'hA500_0000 | 32'(i);
      seeded = 1'b1;
    end
    cyc_n++;
    if (wb_cyc_o && wb_stb_o) n_stb++;
    if (wb_cyc_o && !wb_stb_o) n_gap++;
    if (wb_ack_i && n_beats < 512) begin
      b_addr[n_beats] = wb_addr_o;
      b_cti[n_beats]  = wb_cti_o;
      b_dat[n_beats]  = wb_dat_o;
      b_we[n_beats]   = wb_we_o;
      b_cyc[n_beats]  = cyc_n;
      if (wb_we_o)
        for (int b = 0; b < 4; b++)
          if (wb_sel_o[b])
            mem[wb_addr_o[11:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
      n_beats++;
    end
    if (rdat_valid && n_rd < 512) begin
      r_dat[n_rd]  = rdat_data;
      r_last[n_rd] = rdat_last;
      r_cyc[n_rd]  = cyc_n;
      n_rd++;
    end
    if (done) begin
      n_done++;
      done_cyc  = cyc_n;
      done_snap = {cmd_ready, wb_cyc_o, busy};
    end
    if (err) begin
      n_err++;
      err_snap = {wb_cyc_o, wb_stb_o, cmd_ready};
    end
  end

  // write-data source; a handshake is predicted from the
  // ready level, which is stable between negedge and posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      wi = wn;
      wdat_valid = 1'b0;
    end else begin
      phase = ~phase;
      if (wi < wn && (!tog || phase)) begin
        wdat_valid = 1'b1;
        wdat_data  = wq_d[wi];
        wdat_sel   = wq_s[wi];
        if (wdat_ready) wi++;
      end else begin
        wdat_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [14:0] outs();
    return {wb_cyc_o, wb_stb_o, wb_we_o, |wb_addr_o,
            |wb_dat_o, |wb_sel_o, |wb_cti_o, rdat_valid,
            |rdat_data, rdat_last, done, err, busy,
            cmd_ready, wdat_ready};
  endfunction

  task automatic push_w(input logic [31:0] d,
                        input logic [3:0] s);
    wq_d[wn] = d;
    wq_s[wn] = s;
    wn++;
  endtask

  task automatic send_cmd(input logic we,
                          input logic [AW-1:0] a,
                          input logic [3:0] l);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int d0 = n_done;
    int e0 = n_err;
    int k = 0;
    while (n_done == d0 && n_err == e0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_end"}, k < 400, 1);
  endtask

  task automatic merge_ref(input int idx,
                           input logic [31:0] d,
                           input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  initial begin
    int b0, r0, s0, g0, d0, e0, k, idx;
    logic we;
    logic [3:0] len;
    logic [31:0] d;
    logic [3:0] s;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    ack_en = 1'b1;
    tog = 1'b0;
    wn = 0;
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 15'h0002);
    rst_n = 1'b1;

    // burst read, low address bits ignored
    b0 = n_beats; r0 = n_rd; s0 = n_stb;
    send_cmd(1'b0, 26'h102, 4'd3);
    chk("rd_first", {wb_cyc_o, wb_stb_o, wb_addr_o, wb_cti_o},
        {1'b1, 1'b1, 26'h100, 3'b010});
    wait_end("rd4");
    chk("rd4_beats", n_beats - b0, 4);
    chk("rd4_stb", n_stb - s0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd4_addr", b_addr[b0+i], 26'h100 + 26'(4*i));
      chk("rd4_cti", b_cti[b0+i], (i == 3) ? 3'b111 : 3'b010);
      chk("rd4_dat", r_dat[r0+i], 32'hA500_0040 + 32'(i));
      chk("rd4_last", r_last[r0+i], i == 3);
    end
    chk("rd4_nrd", n_rd - r0, 4);
    chk("rd4_lat", r_cyc[r0] - b_cyc[b0], 1);
    chk("rd4_done_t", done_cyc - b_cyc[b0+3], 1);
    chk("fin_snap", done_snap, 3'b001);

    // single classic write, then read it back
    b0 = n_beats; s0 = n_stb;
    push_w(32'hDEAD_BEEF, 4'hF);
    send_cmd(1'b1, 26'h200, 4'd0);
    wait_end("wr1");
    chk("wr1_stb", n_stb - s0, 1);
    chk("wr1_beat", {b_we[b0], b_cti[b0], b_dat[b0]},
        {1'b1, 3'b000, 32'hDEAD_BEEF});
    chk("wr1_mem", mem[10'h080], 32'hDEAD_BEEF);
    r0 = n_rd; b0 = n_beats;
    send_cmd(1'b0, 26'h200, 4'd0);
    wait_end("rb1");
    chk("rb1_cti", b_cti[b0], 3'b000);
    chk("rb1_dat", {r_dat[r0], r_last[r0]},
        {32'hDEAD_BEEF, 1'b1});

    // streamed write, no data gaps
    b0 = n_beats; s0 = n_stb; g0 = n_gap;
    for (int i = 0; i < 4; i++) push_w(32'h2000_0000 + 32'(i), 4'hF);
    send_cmd(1'b1, 26'h400, 4'd3);
    wait_end("wr4");
    chk("wr4_stb", n_stb - s0, 4);
    chk("wr4_gap", n_gap - g0, 1);
    chk("wr4_dat3", b_dat[b0+3], 32'h2000_0003);

    // gappy write burst, stb drops with cyc held
    tog = 1'b1;
    b0 = n_beats; g0 = n_gap; e0 = n_err; d0 = n_done;
    for (int i = 0; i < 8; i++) push_w(32'h1000_0000 + 32'(i), 4'hF);
    send_cmd(1'b1, 26'h300, 4'd7);
    wait_end("wr8");
    tog = 1'b0;
    chk("wr8_beats", n_beats - b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("wr8_dat", b_dat[b0+i], 32'h1000_0000 + 32'(i));
      chk("wr8_addr", b_addr[b0+i], 26'h300 + 26'(4*i));
    end
    chk("wr8_cti7", b_cti[b0+7], 3'b111);
    chk("wr8_gaps", (n_gap - g0) > 1, 1);
    chk("wr8_noerr", n_err - e0, 0);
    chk("wr8_done", n_done - d0, 1);

    // address wraps at the top of the space
    b0 = n_beats; r0 = n_rd;
    send_cmd(1'b0, 26'h3FF_FFFC, 4'd1);
    wait_end("wrap");
    chk("wrap_a1", b_addr[b0+1], 26'h0);
    chk("wrap_d0", r_dat[r0], 32'hA500_03FF);
    chk("wrap_d1", r_dat[r0+1], 32'hA500_0000);

    // slave never acks: watchdog abort
    ack_en = 1'b0;
    s0 = n_stb; d0 = n_done; e0 = n_err; r0 = n_rd;
    send_cmd(1'b0, 26'h500, 4'd1);
    wait_end("to");
    ack_en = 1'b1;
    chk("to_err", n_err - e0, 1);
    chk("to_stb", n_stb - s0, TO);
    chk("to_nodone", n_done - d0, 0);
    chk("to_nord", n_rd - r0, 0);
    chk("to_snap", err_snap, 3'b001);
    d0 = n_done;
    send_cmd(1'b0, 26'h100, 4'd0);
    wait_end("to_next");
    chk("to_next_done", n_done - d0, 1);

    // reset in the middle of a write burst
    b0 = n_beats;
    for (int i = 0; i < 8; i++) push_w(32'h3000_0000 + 32'(i), 4'hF);
    send_cmd(1'b1, 26'h600, 4'd7);
    k = 0;
    while (n_beats - b0 < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk("rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", outs(), 15'h0002);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = n_rd; d0 = n_done;
    send_cmd(1'b0, 26'h100, 4'd0);
    wait_end("post_rst");
    chk("post_rst_dat", r_dat[r0], 32'hA500_0040);
    chk("post_rst_done", n_done - d0, 1);

    // back-to-back random traffic against a reference
    for (int c = 0; c < 12; c++) begin
      we  = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      len = 4'($urandom_range(0, 15));
      idx = 512 + $urandom_range(0, 40);
      tog = 1'($urandom_range(0, 1));
      r0 = n_rd;
      if (we) begin
        for (int j = 0; j <= int'(len); j++) begin
          d = $urandom;
          s = 4'($urandom_range(1, 15));
          push_w(d, s);
          merge_ref(idx + j, d, s);
        end
      end
      send_cmd(we, 26'(idx * 4), len);
      wait_end("rnd");
      if (!we) begin
        chk("rnd_nrd", n_rd - r0, int'(len) + 1);
        for (int j = 0; j <= int'(len); j++)
          chk("rnd_dat", r_dat[r0+j], ref_mem[idx+j]);
      end
    end
    tog = 1'b0;
    for (int j = 512; j < 572; j += 7)
      chk("rnd_mem", mem[j], ref_mem[j]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
